// File: rtl/btn_irq_debouncer_if.sv
// Button/interrupt bundle between the board/MCU side (master) and the debouncer (slave).
// Signal names follow the MCU wrapper's port names.
interface btn_irq_debouncer_if;
  logic       BTN_IN;
  logic       INT_ACK;
  logic       INTERRUPT;
  logic       BTN_LEVEL;
  logic [7:0] PRESS_CNT;
  logic       OVERRUN;

  modport master (
    output BTN_IN,
    output INT_ACK,
    input  INTERRUPT,
    input  BTN_LEVEL,
    input  PRESS_CNT,
    input  OVERRUN
  );

  modport slave (
    input  BTN_IN,
    input  INT_ACK,
    output INTERRUPT,
    output BTN_LEVEL,
    output PRESS_CNT,
    output OVERRUN
  );
endinterface

// File: rtl/btn_irq_debouncer.sv
// Debounces a raw button into a clean level and one latched interrupt per press (cleared by INT_ACK).
// Press/release accepted DB_COUNT+2 edges after first sample; BTN_RELEASE_IRQ_EN also raises the request on release.
module btn_irq_debouncer #(
  parameter int DB_COUNT = 500_000,
  parameter int CNT_W    = 20
) (
  input  logic                CLK,
  input  logic                RST_N,
  btn_irq_debouncer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

`ifdef BTN_RELEASE_IRQ_EN
  localparam bit REL_IRQ_EN = 1'b1;
`else
  localparam bit REL_IRQ_EN = 1'b0;
`endif

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             irq_q, irq_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic             ovr_q, ovr_d;
  logic             press_evt;
  logic             release_evt;
  logic             irq_evt;

  always_comb begin
    s1_d        = bus.BTN_IN;
    s2_d        = s1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;

    unique case (state_q)
      IDLE_LOW: begin
        if (s2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2_q) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HELD_HIGH;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD_HIGH: begin
        if (!s2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2_q) begin
          state_d = HELD_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE_LOW;
          release_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
      end
    endcase

    // Level follows the state being entered so it changes on the accepting edge.
    lvl_d       = (state_d == HELD_HIGH) || (state_d == WAIT_LOW);
    press_cnt_d = press_cnt_q + {7'd0, press_evt};

    irq_evt = press_evt | (REL_IRQ_EN & release_evt);
    irq_d   = irq_q;
    ovr_d   = ovr_q;
    // A fresh event beats a same-cycle ack; only an unacked collision is an overrun.
    if (irq_evt) begin
      irq_d = 1'b1;
      if (irq_q && !bus.INT_ACK) begin
        ovr_d = 1'b1;
      end
    end else if (bus.INT_ACK) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      state_q     <= IDLE_LOW;
      cnt_q       <= '0;
      lvl_q       <= 1'b0;
      irq_q       <= 1'b0;
      press_cnt_q <= 8'd0;
      ovr_q       <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lvl_q       <= lvl_d;
      irq_q       <= irq_d;
      press_cnt_q <= press_cnt_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.INTERRUPT = irq_q;
  assign bus.BTN_LEVEL = lvl_q;
  assign bus.PRESS_CNT = press_cnt_q;
  assign bus.OVERRUN   = ovr_q;

endmodule
